smooth_sweep_sequencer: RTL and testbench
=========================================

# smooth_sweep_sequencer

Sequencer for the boxcar ADC smoother in the Mossbauer acquisition path. After each start it flushes and refills the smoother window. It then steps a velocity-channel index with a programmable dwell, and emits one sampling strobe per channel so downstream binning captures the smoothed value for the correct channel. It sits between the run-control registers and the smoother / channel-histogram logic, in the `adc_clk` domain.

## Interface
- `WINDOW`, 1024: smoother window length in samples (power of two).
- `PIPE_LAT`, 3: smoother register latency from raw input to `smooth_data`.
- `CH_WIDTH`, 10: channel index width.
- `DWELL_WIDTH`, 16: dwell counter width.
- `SWEEP_WIDTH`, 32: sweep counter width.

Ports:
- `adc_clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle run request; honoured only in IDLE.
- `stop`  in  1  abort; honoured in every state.
- `cfg_dwell`  in  DWELL_WIDTH  clocks per channel; 0 treated as 1.
- `cfg_last_ch`  in  CH_WIDTH  highest channel index (channels = value+1).
- `cfg_sync_en`  in  1  enable external sweep resync.
- `ext_sync`  in  1  level from the velocity drive; a rising edge marks the sweep origin.
- `data_gate`  out  1  forces the smoother input to zero.
- `smooth_valid`  out  1  smoother window holds only post-start samples.
- `chan_idx`  out  CH_WIDTH  current channel.
- `chan_strobe`  out  1  one-cycle pulse on the last dwell cycle of `chan_idx`.
- `sweep_start`  out  1  one-cycle pulse on the first cycle of channel 0.
- `sweep_count`  out  SWEEP_WIDTH  completed-or-started sweeps since start.
- `busy`  out  1  state ≠ IDLE.
- `state`  out  2  IDLE=0, FLUSH=1, WARM=2, RUN=3.

## Operation
- **Config latch:** `cfg_dwell`, `cfg_last_ch` and `cfg_sync_en` are latched on the accepted `start`. Changes while busy have no effect until the next run.
- **IDLE → FLUSH:** on `start` with `stop`=0.
- **FLUSH:**
  - `data_gate`=1.
  - Lasts exactly WINDOW cycles, then goes to WARM.
- **WARM:**
  - `data_gate`=0.
  - Lasts WINDOW+PIPE_LAT cycles, then goes to RUN.
- **RUN:**
  - `smooth_valid`=1.
  - Dwell counter counts 0..dwell−1.
  - `chan_strobe`=1 when the counter equals dwell−1. The next cycle, the counter goes to 0 and `chan_idx` increments.
  - `chan_idx` wraps `cfg_last_ch`→0.
  - `sweep_start` fires on the first RUN cycle and on every cycle where `chan_idx` becomes 0. `sweep_count` increments in the same cycle.
- **Resync:** `ext_sync` is registered once; the edge is detected on the registered copy (1-cycle latency). A detected rising edge in RUN with `cfg_sync_en`=1:
  - forces the dwell counter to 0 and `chan_idx`=0;
  - pulses `sweep_start` and increments `sweep_count`;
  - suppresses `chan_strobe` in that cycle, so the truncated channel is discarded.
  Edges in other states are ignored.
- **Resync coinciding with a natural wrap:** counts once; one `sweep_start`, `sweep_count` +1.
- **Stop:** `stop` in any state → IDLE next cycle. Any `chan_strobe` and `sweep_start` in that cycle are suppressed. `sweep_count` is held (not cleared) until the next start.
- **Start and stop in the same IDLE cycle:** `stop` wins; the block stays in IDLE.
- **Counter widths:** `sweep_count` wraps modulo 2^SWEEP_WIDTH. `chan_idx` never exceeds `cfg_last_ch`.
- **Reset values:**
  - state IDLE;
  - `data_gate`, `smooth_valid`, `chan_strobe`, `sweep_start`, `busy` = 0;
  - `chan_idx`=0, `sweep_count`=0;
  - latched config: dwell 1, last_ch 0, sync_en 0.
- **Counter clear on start:** `sweep_count` and `chan_idx` clear on the accepted `start`.

## Timing
- All outputs are registered and change only on `adc_clk`.
- Start accepted at cycle t:
  - FLUSH covers t+1..t+WINDOW;
  - WARM covers t+WINDOW+1..t+2·WINDOW+PIPE_LAT;
  - first RUN cycle (`sweep_start`=1, `chan_idx`=0) is t+2·WINDOW+PIPE_LAT+1.
- First `chan_strobe` occurs dwell−1 cycles after the first RUN cycle.
- `ext_sync` rising edge at cycle s produces the resync effects visible at s+2.
- `rst` has priority over everything and takes effect the next cycle, including mid-RUN.

## Structure
- Shared package `mossbauer_pkg`:
  - state enum (IDLE/FLUSH/WARM/RUN);
  - the default WINDOW and PIPE_LAT constants, also used by the smoother's shift by log2(WINDOW).
- Sub-module `channel_stepper`: dwell counter, channel index with wrap, and resync/suppress logic, enabled only in RUN.
- Top level: phase FSM, phase counter, config latch, `ext_sync` edge detector.

## Test plan
All scenarios use WINDOW=8 and PIPE_LAT=3.

- **Basic run.** Stimulus: reset, then `start` at t=10 with dwell=4, last_ch=2. Required:
  - `data_gate` high t+1..t+8;
  - RUN begins t+20 with `sweep_start`;
  - strobes at t+23, t+27, t+31 for `chan_idx` 0, 1, 2;
  - `sweep_start` again at t+32 with `sweep_count`=2.
- **Dwell zero.** Stimulus: dwell=0. Required: `chan_strobe` every RUN cycle; `chan_idx` cycles 0, 1, 2, 0.
- **Resync.** Stimulus: `cfg_sync_en`=1, dwell=10, `ext_sync` rising mid-channel 1. Required:
  - two cycles later, `chan_idx`=0, `sweep_start`=1, no strobe that cycle;
  - `sweep_count` +1.
- **Resync on wrap.** Stimulus: `ext_sync` edge timed so its effect coincides with the last→0 wrap. Required: single `sweep_start`, `sweep_count` +1 only.
- **Stop.** Stimulus: `stop` asserted on a strobe cycle. Required:
  - no strobe that cycle;
  - IDLE next cycle, `busy`=0;
  - `sweep_count` held.
- **Ignored and abort cases.** Stimulus: `start` during WARM; then `start`+`stop` together in IDLE; then `rst` mid-RUN. Required:
  - the extra `start` is ignored;
  - the combined `start`+`stop` stays in IDLE;
  - `rst` returns all outputs to their reset values one cycle later.

Source files
------------

// File: rtl/mossbauer_pkg.sv
// Shared definitions for the Mossbauer acquisition path: sequencer phases and smoother geometry.
// The smoother divides its running sum by shifting right DEF_WINDOW_SHIFT bits.
package mossbauer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WARM  = 2'd2,
        RUN   = 2'd3
    } seq_state_e;

    localparam int DEF_WINDOW       = 1024;
    localparam int DEF_PIPE_LAT     = 3;
    localparam int DEF_WINDOW_SHIFT = $clog2(DEF_WINDOW);

endpackage

// File: rtl/channel_stepper.sv
// Dwell counter and velocity-channel index for the RUN phase; all outputs registered (1-cycle latency).
// Idles while step_i/enter_run_i are low, so a stop simply freezes the channel and sweep count.
module channel_stepper #(
    parameter int CH_WIDTH    = 10,
    parameter int DWELL_WIDTH = 16,
    parameter int SWEEP_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   enter_run_i,
    input  logic                   step_i,
    input  logic                   resync_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    input  logic [CH_WIDTH-1:0]    last_ch_i,
    output logic [CH_WIDTH-1:0]    chan_idx_o,
    output logic                   chan_strobe_o,
    output logic                   sweep_start_o,
    output logic [SWEEP_WIDTH-1:0] sweep_count_o
);

    logic [DWELL_WIDTH-1:0] dcnt_q, dcnt_d, dwell_m1;
    logic [CH_WIDTH-1:0]    chan_q, chan_d;
    logic [SWEEP_WIDTH-1:0] count_q, count_d;
    logic                   strobe_q, strobe_d;
    logic                   sstart_q, sstart_d;

    // dwell_i is never zero here, so dwell_m1 cannot underflow.
    always_comb begin
        dwell_m1 = dwell_i - DWELL_WIDTH'(1);
        dcnt_d   = dcnt_q;
        chan_d   = chan_q;
        count_d  = count_q;
        strobe_d = 1'b0;
        sstart_d = 1'b0;
        if (clear_i) begin
            dcnt_d  = '0;
            chan_d  = '0;
            count_d = '0;
        end else if (enter_run_i) begin
            dcnt_d   = '0;
            chan_d   = '0;
            sstart_d = 1'b1;
            count_d  = count_q + SWEEP_WIDTH'(1);
            strobe_d = (dwell_m1 == '0);
        end else if (step_i) begin
            if (resync_i) begin
                // Truncated channel is dropped: no strobe on the resync cycle.
                dcnt_d   = '0;
                chan_d   = '0;
                sstart_d = 1'b1;
                count_d  = count_q + SWEEP_WIDTH'(1);
            end else if (dcnt_q == dwell_m1) begin
                dcnt_d   = '0;
                strobe_d = (dwell_m1 == '0);
                if (chan_q == last_ch_i) begin
                    chan_d   = '0;
                    sstart_d = 1'b1;
                    count_d  = count_q + SWEEP_WIDTH'(1);
                end else begin
                    chan_d = chan_q + CH_WIDTH'(1);
                end
            end else begin
                dcnt_d   = dcnt_q + DWELL_WIDTH'(1);
                strobe_d = ((dcnt_q + DWELL_WIDTH'(1)) == dwell_m1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dcnt_q   <= '0;
            chan_q   <= '0;
            count_q  <= '0;
            strobe_q <= 1'b0;
            sstart_q <= 1'b0;
        end else begin
            dcnt_q   <= dcnt_d;
            chan_q   <= chan_d;
            count_q  <= count_d;
            strobe_q <= strobe_d;
            sstart_q <= sstart_d;
        end
    end

    assign chan_idx_o    = chan_q;
    assign chan_strobe_o = strobe_q;
    assign sweep_start_o = sstart_q;
    assign sweep_count_o = count_q;

endmodule

// File: rtl/smooth_sweep_sequencer.sv
// Run sequencer: flushes and refills the boxcar smoother, then steps velocity channels with a dwell.
// Registered outputs; stop aborts from any state, rst overrides everything on the next edge.
module smooth_sweep_sequencer
    import mossbauer_pkg::*;
#(
    parameter int WINDOW      = DEF_WINDOW,
    parameter int PIPE_LAT    = DEF_PIPE_LAT,
    parameter int CH_WIDTH    = 10,
    parameter int DWELL_WIDTH = 16,
    parameter int SWEEP_WIDTH = 32
) (
    input  logic                   adc_clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [CH_WIDTH-1:0]    cfg_last_ch,
    input  logic                   cfg_sync_en,
    input  logic                   ext_sync,
    output logic                   data_gate,
    output logic                   smooth_valid,
    output logic [CH_WIDTH-1:0]    chan_idx,
    output logic                   chan_strobe,
    output logic                   sweep_start,
    output logic [SWEEP_WIDTH-1:0] sweep_count,
    output logic                   busy,
    output logic [1:0]             state
);

    localparam int PH_W = $clog2(WINDOW + PIPE_LAT);
    localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(WINDOW - 1);
    localparam logic [PH_W-1:0] WARM_LAST  = PH_W'(WINDOW + PIPE_LAT - 1);

    seq_state_e             state_q;
    logic [PH_W-1:0]        phase_q;
    logic                   data_gate_q, smooth_valid_q, busy_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [CH_WIDTH-1:0]    last_ch_q;
    logic                   sync_en_q;
    logic                   ext_q, ext_qq;
    logic                   accept, enter_run, step, resync;

    assign accept    = (state_q == IDLE) && start && !stop;
    assign enter_run = (state_q == WARM) && (phase_q == WARM_LAST) && !stop;
    assign step      = (state_q == RUN) && !stop;
    assign resync    = step && sync_en_q && ext_q && !ext_qq;

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            ext_q  <= 1'b0;
            ext_qq <= 1'b0;
        end else begin
            ext_q  <= ext_sync;
            ext_qq <= ext_q;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            data_gate_q    <= 1'b0;
            smooth_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            dwell_q        <= DWELL_WIDTH'(1);
            last_ch_q      <= '0;
            sync_en_q      <= 1'b0;
        end else if (stop) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            data_gate_q    <= 1'b0;
            smooth_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q     <= FLUSH;
                    phase_q     <= '0;
                    data_gate_q <= 1'b1;
                    busy_q      <= 1'b1;
                    dwell_q     <= (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
                    last_ch_q   <= cfg_last_ch;
                    sync_en_q   <= cfg_sync_en;
                end
                FLUSH: if (phase_q == FLUSH_LAST) begin
                    state_q     <= WARM;
                    phase_q     <= '0;
                    data_gate_q <= 1'b0;
                end else begin
                    phase_q <= phase_q + PH_W'(1);
                end
                // WARM also covers the smoother pipeline so the first RUN sample is clean.
                WARM: if (phase_q == WARM_LAST) begin
                    state_q        <= RUN;
                    phase_q        <= '0;
                    smooth_valid_q <= 1'b1;
                end else begin
                    phase_q <= phase_q + PH_W'(1);
                end
                RUN: state_q <= RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    channel_stepper #(
        .CH_WIDTH    (CH_WIDTH),
        .DWELL_WIDTH (DWELL_WIDTH),
        .SWEEP_WIDTH (SWEEP_WIDTH)
    ) u_stepper (
        .clk_i         (adc_clk),
        .rst_i         (rst),
        .clear_i       (accept),
        .enter_run_i   (enter_run),
        .step_i        (step),
        .resync_i      (resync),
        .dwell_i       (dwell_q),
        .last_ch_i     (last_ch_q),
        .chan_idx_o    (chan_idx),
        .chan_strobe_o (chan_strobe),
        .sweep_start_o (sweep_start),
        .sweep_count_o (sweep_count)
    );

    assign data_gate    = data_gate_q;
    assign smooth_valid = smooth_valid_q;
    assign busy         = busy_q;
    assign state        = state_q;

endmodule

// File: tb/tb_smooth_sweep_sequencer.sv
// Bench for smooth_sweep_sequencer with WINDOW=8, PIPE_LAT=3: directed scenarios plus random runs,
// every cycle compared against a closed-form timeline model of the sweep.
module tb_smooth_sweep_sequencer;

    localparam int W    = 8;
    localparam int P    = 3;
    localparam int RUN0 = 2 * W + P + 1;

    logic        adc_clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, stop = 1'b0, cfg_sync_en = 1'b0, ext_sync = 1'b0;
    logic [15:0] cfg_dwell = '0;
    logic [9:0]  cfg_last_ch = '0;
    logic        data_gate, smooth_valid, chan_strobe, sweep_start, busy;
    logic [9:0]  chan_idx;
    logic [31:0] sweep_count;
    logic [1:0]  state;

    smooth_sweep_sequencer #(
        .WINDOW(W), .PIPE_LAT(P), .CH_WIDTH(10), .DWELL_WIDTH(16), .SWEEP_WIDTH(32)
    ) dut (
        .adc_clk(adc_clk), .rst(rst), .start(start), .stop(stop),
        .cfg_dwell(cfg_dwell), .cfg_last_ch(cfg_last_ch), .cfg_sync_en(cfg_sync_en),
        .ext_sync(ext_sync), .data_gate(data_gate), .smooth_valid(smooth_valid),
        .chan_idx(chan_idx), .chan_strobe(chan_strobe), .sweep_start(sweep_start),
        .sweep_count(sweep_count), .busy(busy), .state(state)
    );

    always #5 adc_clk = ~adc_clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit ext_hist [0:4095];

    // Reference model: the run is a timeline measured from the accepted start and the sweep origin.
    bit m_active = 0, m_sen = 0, m_rs_org = 0;
    int m_t = 0, m_d = 1, m_L = 0, m_origin = 0, m_base = 0, m_chan = 0, m_cnt = 0;
    int e_state, e_gate, e_valid, e_busy, e_chan, e_strobe, e_ss, e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update(input bit p_rst, input bit p_start, input bit p_stop,
                                input bit p_sen, input int pd, input int pl);
        int r, k, per;
        if (p_rst) begin
            m_active = 0; m_chan = 0; m_cnt = 0;
        end else if (p_stop) begin
            m_active = 0;
        end else if (!m_active && p_start) begin
            m_active = 1; m_t = cyc - 1; m_d = (pd == 0) ? 1 : pd; m_L = pl; m_sen = p_sen;
            m_chan = 0; m_cnt = 0; m_origin = m_t + RUN0; m_base = 1; m_rs_org = 0;
        end
        e_gate = 0; e_valid = 0; e_strobe = 0; e_ss = 0;
        e_busy = m_active ? 1 : 0;
        if (!m_active) begin
            e_state = 0; e_chan = m_chan; e_cnt = m_cnt;
        end else begin
            r = cyc - m_t;
            if (r <= W) begin
                e_state = 1; e_gate = 1; e_chan = 0; e_cnt = 0;
            end else if (r < RUN0) begin
                e_state = 2; e_chan = 0; e_cnt = 0;
            end else begin
                e_state = 3; e_valid = 1;
                if (m_sen && (cyc - 1 >= m_t + RUN0) && ext_hist[cyc-2] && !ext_hist[cyc-3]) begin
                    m_base = m_cnt + 1; m_origin = cyc; m_rs_org = 1;
                end
                k        = cyc - m_origin;
                per      = m_d * (m_L + 1);
                e_chan   = (k / m_d) % (m_L + 1);
                e_cnt    = m_base + k / per;
                e_ss     = (k % per == 0) ? 1 : 0;
                e_strobe = ((k % m_d == m_d - 1) && !(m_rs_org && k == 0)) ? 1 : 0;
            end
            m_chan = e_chan; m_cnt = e_cnt;
        end
    endtask

    task automatic tick();
        bit p_rst, p_start, p_stop, p_sen;
        int pd, pl;
        p_rst = rst; p_start = start; p_stop = stop; p_sen = cfg_sync_en;
        pd = int'(cfg_dwell); pl = int'(cfg_last_ch);
        ext_hist[cyc] = ext_sync;
        @(posedge adc_clk);
        #1;
        cyc++;
        model_update(p_rst, p_start, p_stop, p_sen, pd, pl);
        chk("state", 32'(state), e_state);
        chk("busy", 32'(busy), e_busy);
        chk("data_gate", 32'(data_gate), e_gate);
        chk("smooth_valid", 32'(smooth_valid), e_valid);
        chk("chan_idx", 32'(chan_idx), e_chan);
        chk("chan_strobe", 32'(chan_strobe), e_strobe);
        chk("sweep_start", 32'(sweep_start), e_ss);
        chk("sweep_count", sweep_count, e_cnt);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_start(input int d, input int l, input bit s);
        cfg_dwell = 16'(d); cfg_last_ch = 10'(l); cfg_sync_en = s; start = 1'b1;
        tick();
        start = 1'b0;
        cfg_dwell = 16'd7; cfg_last_ch = 10'd5; cfg_sync_en = ~s;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int t0, s, n;

        // Reset state
        tick(); tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_count", sweep_count, 0);
        rst = 1'b0;

        // Basic run: start at t=10, dwell 4, last_ch 2
        run_to(10);
        do_start(4, 2, 1'b0);
        chk("basic_gate_t1", 32'(data_gate), 1);
        run_to(18); chk("basic_gate_t8", 32'(data_gate), 1);
        tick();     chk("basic_gate_t9", 32'(data_gate), 0);
        run_to(30); chk("basic_run_ss", 32'(sweep_start), 1); chk("basic_run_state", 32'(state), 3);
        run_to(33); chk("basic_strobe0", 32'(chan_strobe), 1); chk("basic_ch0", 32'(chan_idx), 0);
        run_to(37); chk("basic_strobe1", 32'(chan_strobe), 1); chk("basic_ch1", 32'(chan_idx), 1);
        run_to(41); chk("basic_strobe2", 32'(chan_strobe), 1); chk("basic_ch2", 32'(chan_idx), 2);
        run_to(42); chk("basic_wrap_ss", 32'(sweep_start), 1); chk("basic_wrap_cnt", sweep_count, 2);

        // Stop at the edge that would produce the next strobe (t+35)
        run_to(44);
        do_stop();
        chk("stop_no_strobe", 32'(chan_strobe), 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_cnt_held", sweep_count, 2);
        tick(); tick();
        chk("stop_cnt_idle", sweep_count, 2);

        // Dwell zero, with an ignored start during WARM
        t0 = cyc;
        do_start(0, 2, 1'b0);
        run_to(t0 + W + 3);
        start = 1'b1; tick(); start = 1'b0;
        chk("warm_start_ign", 32'(state), 2);
        run_to(t0 + RUN0);     chk("d0_strobe_a", 32'(chan_strobe), 1); chk("d0_ch_a", 32'(chan_idx), 0);
        tick();                chk("d0_strobe_b", 32'(chan_strobe), 1); chk("d0_ch_b", 32'(chan_idx), 1);
        tick();                chk("d0_ch_c", 32'(chan_idx), 2);
        tick();                chk("d0_ch_d", 32'(chan_idx), 0); chk("d0_cnt", sweep_count, 2);
        do_stop();

        // start + stop together in IDLE
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("startstop_idle", 32'(state), 0);
        tick(); tick();
        chk("startstop_busy", 32'(busy), 0);

        // Resync mid-channel 1, then resync timed onto the natural wrap
        t0 = cyc;
        do_start(10, 3, 1'b1);
        run_to(t0 + RUN0 + 15);
        s = cyc;
        ext_sync = 1'b1;
        tick(); tick();
        chk("rs_chan", 32'(chan_idx), 0);
        chk("rs_ss", 32'(sweep_start), 1);
        chk("rs_nostrobe", 32'(chan_strobe), 0);
        chk("rs_cnt", sweep_count, 2);
        tick(); ext_sync = 1'b0;
        run_to(s + 40);
        ext_sync = 1'b1;
        tick(); tick();
        chk("rswrap_ss", 32'(sweep_start), 1);
        chk("rswrap_cnt", sweep_count, 3);
        ext_sync = 1'b0;
        tick();
        chk("rswrap_single", 32'(sweep_start), 0);
        chk("rswrap_cnt_hold", sweep_count, 3);
        do_stop();

        // Random runs against the model; the last one ends with rst mid-RUN
        for (int run = 0; run < 6; run++) begin
            do_start($urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            n = RUN0 + $urandom_range(10, 60);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 6) == 0) ext_sync = ~ext_sync;
                tick();
            end
            if (run == 5) begin
                rst = 1'b1; tick(); rst = 1'b0;
                chk("rst_run_state", 32'(state), 0);
                chk("rst_run_chan", 32'(chan_idx), 0);
                chk("rst_run_cnt", sweep_count, 0);
                chk("rst_run_valid", 32'(smooth_valid), 0);
            end else begin
                do_stop();
            end
            tick(); tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
